addsub_arbiter: RTL and testbench
=================================

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameter: FIRST_PRIO, default 0, requester index (0/1) holding priority after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_x, req0_y  input  16 each  operands; req0_sub input 1: 1 = X-Y, 0 = X+Y.
REQ-007 req1_valid, req1_ready, req1_x, req1_y, req1_sub  same widths and meaning for requester 1.
REQ-008 resp_valid  output  1  result available.
REQ-009 resp_ready  input  1  consumer accepts result.
REQ-010 resp_id  output  1  index of requester that issued the result.
REQ-011 resp_s  output  16  sum/difference; resp_cout output 1 carry out; resp_ov output 1 signed overflow.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, EXEC, RESP.
REQ-014 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally that cycle, register x, y, sub, id; next state EXEC.
REQ-015 Arbitration: only one valid -> grant it; both valid -> grant priority pointer; pointer moves to the non-granted index after every grant.
REQ-016 reqN_ready SHALL be 0 outside IDLE and 0 for the non-granted requester.
REQ-017 EXEC: shared add/sub unit driven only from registered operands, Cin = registered sub; resp_s, resp_cout, resp_ov, resp_id registered at end of cycle; next state RESP.
REQ-018 resp_ov SHALL be computed in this block: t15 = y15 XOR sub; ov = (x15 == t15) AND (s15 != x15); the unit's own Ov output is unused.
REQ-019 RESP: resp_valid = 1; resp_s/cout/ov/id held stable until resp_valid AND resp_ready; then next state IDLE.
REQ-020 Latency: accept in cycle N -> resp_valid first high in cycle N+2; minimum 3 cycles per operation; no new accept in the cycle of response handshake.
REQ-021 Arithmetic is modulo 2^16; cout = carry out of bit 15 (for subtract, cout = 1 means no borrow).
REQ-022 reqN_valid deasserting while not granted SHALL have no effect; operands sampled only in the accept cycle.

Reset
REQ-023 rst in any state SHALL on the next edge force IDLE, pointer = FIRST_PRIO, resp_valid = 0, busy = 0, resp_s = 0, resp_cout = 0, resp_ov = 0, resp_id = 0.
REQ-024 An operation in EXEC or RESP at reset SHALL be discarded with no response; reqN_ready SHALL be 0 while rst is high.

Structure
REQ-025 Shared package addsub_pkg SHALL hold the state encoding (IDLE, EXEC, RESP) and DATA_W = 16.
REQ-026 One sub-module instance: twos_complement_add_sub (X, Y, Cin, Cout, Ov, S); all other logic in this module.

Verification
REQ-027 req0 x=0x0005 y=0x0003 sub=0 -> two cycles later resp_valid, s=0x0008, cout=0, ov=0, id=0.
REQ-028 req1 x=0x0003 y=0x0005 sub=1 -> s=0xFFFE, cout=0, ov=0, id=1; x=0x8000 y=0x0001 sub=1 -> s=0x7FFF, cout=1, ov=1.
REQ-029 x=0x7FFF y=0x0001 sub=0 -> s=0x8000, cout=0, ov=1; x=0xFFFF y=0x0001 sub=0 -> s=0x0000, cout=1, ov=0.
REQ-030 Both valid continuously, FIRST_PRIO=0, resp_ready=1 -> grants and resp_id sequence 0,1,0,1, one accept every 3 cycles.
REQ-031 resp_ready held low 5 cycles in RESP -> resp_valid and all result fields stable, both reqN_ready = 0, busy = 1.
REQ-032 rst pulsed during EXEC with req1 pending -> next cycle state IDLE, resp_valid=0, busy=0, no response emitted; next grant follows FIRST_PRIO.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub arbiter.
//   DATA_W      operand / result width
//   state_t     controller states: IDLE (waiting for a request), EXEC (adder
//               evaluating registered operands), RESP (result held for consumer)
//   signed_ov   signed overflow flag derived from operand and result sign bits
package addsub_pkg;

    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Overflow occurs when both effective addends share a sign and the result
    // sign differs. For subtraction the effective second addend is ~y, so its
    // sign bit is y15 ^ sub.
    function automatic logic signed_ov(input logic x15, input logic y15,
                                       input logic sub, input logic s15);
        logic t15;
        t15 = y15 ^ sub;
        return (x15 == t15) && (s15 != x15);
    endfunction

endpackage

// File: rtl/twos_complement_add_sub.sv
// Two's complement adder/subtractor.
//   Parameter W   data width
//   X, Y          operands
//   Cin           1 = X - Y (Y inverted, carry-in 1), 0 = X + Y
//   S             result modulo 2^W
//   Cout          carry out of the MSB (for subtract: 1 = no borrow)
//   Ov            signed overflow (carry into MSB xor carry out of MSB)
module twos_complement_add_sub #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    input  logic         Cin,
    output logic         Cout,
    output logic         Ov,
    output logic [W-1:0] S
);

    logic [W-1:0] y_eff;
    logic [W:0]   full_sum;
    logic [W-1:0] low_sum;
    logic         carry_into_msb;

    always_comb begin
        y_eff          = Y ^ {W{Cin}};
        full_sum       = {1'b0, X} + {1'b0, y_eff} + {{W{1'b0}}, Cin};
        // Sum of the lower W-1 bits exposes the carry into the MSB.
        low_sum        = {1'b0, X[W-2:0]} + {1'b0, y_eff[W-2:0]} + {{(W-1){1'b0}}, Cin};
        carry_into_msb = low_sum[W-1];
        S              = full_sum[W-1:0];
        Cout           = full_sum[W];
        Ov             = carry_into_msb ^ full_sum[W];
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Two-requester arbiter in front of a single shared add/sub unit.
//   Parameter FIRST_PRIO  requester index (0/1) holding priority after reset
//   clk, rst              clock, synchronous active-high reset
//   reqN_valid/ready      request handshake for requester N (N = 0, 1)
//   reqN_x, reqN_y        operands; reqN_sub: 1 = x - y, 0 = x + y
//   resp_valid/ready      result handshake
//   resp_id               requester that issued the result
//   resp_s, resp_cout     result and carry out of bit 15
//   resp_ov               signed overflow
//   busy                  high whenever the controller is not IDLE
// One operation at a time: accept in IDLE, compute in EXEC, present in RESP.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int unsigned FIRST_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_x,
    input  logic [DATA_W-1:0] req0_y,
    input  logic              req0_sub,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_x,
    input  logic [DATA_W-1:0] req1_y,
    input  logic              req1_sub,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_s,
    output logic              resp_cout,
    output logic              resp_ov,

    output logic              busy
);

    localparam logic PRIO_RST = FIRST_PRIO[0];

    state_t state_q, state_d;

    // Priority pointer: requester that wins when both are valid.
    logic prio_q;

    // Operands captured in the accept cycle.
    logic [DATA_W-1:0] x_q;
    logic [DATA_W-1:0] y_q;
    logic              sub_q;
    logic              id_q;

    // Result registers, loaded at the end of EXEC and held through RESP.
    logic [DATA_W-1:0] s_q;
    logic              cout_q;
    logic              ov_q;
    logic              rid_q;

    logic              accept;
    logic              grant;

    logic [DATA_W-1:0] alu_s;
    logic              alu_cout;
    logic              unused_alu_ov;
    logic              ov_calc;

    // Adder sees only registered operands, so request-side inputs never reach it.
    twos_complement_add_sub #(
        .W (DATA_W)
    ) u_alu (
        .X    (x_q),
        .Y    (y_q),
        .Cin  (sub_q),
        .Cout (alu_cout),
        .Ov   (unused_alu_ov),
        .S    (alu_s)
    );

    always_comb begin
        ov_calc = signed_ov(x_q[DATA_W-1], y_q[DATA_W-1], sub_q, alu_s[DATA_W-1]);
    end

    // Arbitration: a lone valid wins; a tie goes to the priority pointer.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = prio_q;
        end else begin
            grant = req1_valid;
        end
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        resp_valid = 1'b0;
        busy       = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                // Ready stays low during reset so no request sees a false accept.
                if (!rst && (req0_valid || req1_valid)) begin
                    accept     = 1'b1;
                    req0_ready = (grant == 1'b0);
                    req1_ready = (grant == 1'b1);
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= PRIO_RST;
            x_q     <= '0;
            y_q     <= '0;
            sub_q   <= 1'b0;
            id_q    <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ov_q    <= 1'b0;
            rid_q   <= 1'b0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                x_q    <= grant ? req1_x   : req0_x;
                y_q    <= grant ? req1_y   : req0_y;
                sub_q  <= grant ? req1_sub : req0_sub;
                id_q   <= grant;
                // Pointer always moves to the requester that lost (or was idle).
                prio_q <= ~grant;
            end

            if (state_q == EXEC) begin
                s_q    <= alu_s;
                cout_q <= alu_cout;
                ov_q   <= ov_calc;
                rid_q  <= id_q;
            end
        end
    end

    assign resp_s    = s_q;
    assign resp_cout = cout_q;
    assign resp_ov   = ov_q;
    assign resp_id   = rid_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed cases followed by random
// operations, all checked against an integer reference model.
module tb_addsub_arbiter;

    localparam int unsigned FIRST_PRIO = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_x, req0_y, req1_x, req1_y;
    logic        req0_sub, req1_sub;
    logic        resp_valid, resp_ready, resp_id;
    logic [15:0] resp_s;
    logic        resp_cout, resp_ov, busy;

    int checks   = 0;
    int failures = 0;

    // Model state: which requester wins a tie.
    int model_prio;

    always #5 clk = ~clk;

    addsub_arbiter #(
        .FIRST_PRIO (FIRST_PRIO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .req1_sub   (req1_sub),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_s     (resp_s),
        .resp_cout  (resp_cout),
        .resp_ov    (resp_ov),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic from plain integer math: returns {ov, cout, s}.
    function automatic logic [17:0] ref_calc(input logic [15:0] x, input logic [15:0] y,
                                             input logic sub);
        int ux, uy, sx, sy, ru, rs;
        logic [15:0] s;
        logic cout, ov;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        ru = sub ? (ux - uy) : (ux + uy);
        rs = sub ? (sx - sy) : (sx + sy);
        s    = 16'(ru);
        cout = sub ? (ux >= uy) : (ru > 65535);
        ov   = (rs > 32767) || (rs < -32768);
        return {ov, cout, s};
    endfunction

    // One full operation: present requests, check grant, follow through EXEC
    // and RESP (holding resp_ready low for `hold` cycles), end back in IDLE.
    task automatic run_op(input logic v0, input logic [15:0] x0, input logic [15:0] y0,
                          input logic s0, input logic v1, input logic [15:0] x1,
                          input logic [15:0] y1, input logic s1, input int hold,
                          input string tag);
        int          g;
        logic [17:0] exp;
        req0_valid = v0; req0_x = x0; req0_y = y0; req0_sub = s0;
        req1_valid = v1; req1_x = x1; req1_y = y1; req1_sub = s1;
        resp_ready = 1'b0;
        #1;
        g = (v0 && v1) ? model_prio : (v1 ? 1 : 0);
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check({tag, ".ready0"}, 32'(req0_ready), 32'(g == 0));
        check({tag, ".ready1"}, 32'(req1_ready), 32'(g == 1));
        exp = (g == 1) ? ref_calc(x1, y1, s1) : ref_calc(x0, y0, s0);
        model_prio = 1 - g;
        tick();
        // Operands must have been captured already; scramble them.
        req0_x = 16'($urandom); req0_y = 16'($urandom); req0_sub = 1'($urandom);
        req1_x = 16'($urandom); req1_y = 16'($urandom); req1_sub = 1'($urandom);
        #1;
        check({tag, ".exec_busy"}, 32'(busy), 32'd1);
        check({tag, ".exec_rdy"}, 32'({req0_ready, req1_ready}), 32'd0);
        check({tag, ".exec_rv"}, 32'(resp_valid), 32'd0);
        tick();
        check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, ".resp_s"}, 32'(resp_s), 32'(exp[15:0]));
        check({tag, ".resp_cout"}, 32'(resp_cout), 32'(exp[16]));
        check({tag, ".resp_ov"}, 32'(resp_ov), 32'(exp[17]));
        check({tag, ".resp_id"}, 32'(resp_id), 32'(g));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
            check({tag, ".hold_fields"}, {13'd0, resp_id, resp_ov, resp_cout, resp_s},
                  {13'd0, 1'(g), exp[17], exp[16], exp[15:0]});
            check({tag, ".hold_rdy"}, 32'({req0_ready, req1_ready}), 32'd0);
            check({tag, ".hold_busy"}, 32'(busy), 32'd1);
        end
        resp_ready = 1'b1;
        #1;
        check({tag, ".hs_rdy"}, 32'({req0_ready, req1_ready}), 32'd0);
        tick();
        resp_ready = 1'b0;
        #1;
        check({tag, ".after_rv"}, 32'(resp_valid), 32'd0);
        check({tag, ".after_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int        ids[4];
        logic      rv0, rv1;

        rst        = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_x = 16'h1234; req0_y = 16'h4321; req0_sub = 1'b0;
        req1_x = 16'hAAAA; req1_y = 16'h5555; req1_sub = 1'b1;
        resp_ready = 1'b0;
        model_prio = int'(FIRST_PRIO);

        // Reset state; ready must stay low while rst is high even with requests.
        tick();
        tick();
        check("rst.ready", 32'({req0_ready, req1_ready}), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.fields", {13'd0, resp_id, resp_ov, resp_cout, resp_s}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;

        // Directed arithmetic cases.
        run_op(1'b1, 16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 0, "add5p3");
        run_op(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0003, 16'h0005, 1'b1, 0, "sub3m5");
        run_op(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h8000, 16'h0001, 1'b1, 0, "sub_ov");
        run_op(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 0, "add_ov");
        run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 0, "add_wrap");
        run_op(1'b1, 16'h0000, 16'h8000, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 0, "sub_min");

        // Back-pressure: consumer stalls five cycles.
        run_op(1'b1, 16'h1357, 16'h2468, 1'b1, 1'b1, 16'h9999, 16'h1111, 1'b0, 5, "stall");

        // Reset during EXEC with both requesters pending: operation discarded.
        req0_valid = 1'b1; req0_x = 16'h0101; req0_y = 16'h0202; req0_sub = 1'b0;
        req1_valid = 1'b1; req1_x = 16'h0303; req1_y = 16'h0404; req1_sub = 1'b0;
        tick();
        check("rstx.exec_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("rstx.busy", 32'(busy), 32'd0);
        check("rstx.resp_valid", 32'(resp_valid), 32'd0);
        check("rstx.ready", 32'({req0_ready, req1_ready}), 32'd0);
        check("rstx.fields", {13'd0, resp_id, resp_ov, resp_cout, resp_s}, 32'd0);
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        model_prio = int'(FIRST_PRIO);
        tick();
        tick();
        check("rstx.no_resp", 32'(resp_valid), 32'd0);

        // Both valid continuously: grants alternate starting at FIRST_PRIO.
        for (int i = 0; i < 4; i++) begin
            ids[i] = model_prio;
            run_op(1'b1, 16'(100 + i), 16'(7 * i), 1'b0, 1'b1, 16'(200 + i), 16'(3 * i), 1'b1,
                   0, "rr");
        end
        check("rr.seq0", 32'(ids[0]), 32'(FIRST_PRIO));
        check("rr.seq1", 32'(ids[1]), 32'(1 - FIRST_PRIO));
        check("rr.seq2", 32'(ids[2]), 32'(FIRST_PRIO));
        check("rr.seq3", 32'(ids[3]), 32'(1 - FIRST_PRIO));

        // Random operations.
        for (int i = 0; i < 40; i++) begin
            rv0 = 1'($urandom);
            rv1 = 1'($urandom);
            if (!rv0 && !rv1) rv0 = 1'b1;
            run_op(rv0, 16'($urandom), 16'($urandom), 1'($urandom),
                   rv1, 16'($urandom), 16'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
